// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, word-addressed instruction memory with an idle-time load port,
// and an IDLE/RUN/HALT sequencer. Define FETCH_REDIRECT_EN to add branch/jump redirect inputs.
module instr_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic              stall,
`ifdef FETCH_REDIRECT_EN
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
`endif
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMEM_DEPTH - 1);

    state_t            state, state_nxt;
    logic [31:0]       pc_nxt;
    logic [15:0]       count_nxt;
    logic [31:0]       imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       fetched;
    logic              is_halt_word;
    logic              at_last;
    logic [15:0]       count_inc;

    assign word_idx     = pc[ADDR_W+1:2];
    assign fetched      = imem[word_idx];
    assign is_halt_word = (fetched == HALT_WORD);
    assign at_last      = (word_idx == LAST_IDX);
    assign count_inc    = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

`ifdef FETCH_REDIRECT_EN
    logic [31:0] redirect_tgt;
    logic        redirect_oob;

    assign redirect_tgt = redirect_pc & ~32'h3;
    assign redirect_oob = |redirect_tgt[31:ADDR_W+2];
`endif

    // NOTE: the memory has no reset so it maps onto plain RAM; a program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE)
            imem[load_addr] <= load_data;
    end

    // NOTE: every output and next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        count_nxt   = instr_count;
        load_ready  = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'h0;
        halted      = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_PC;
                    count_nxt = 16'h0;
                end
            end
            RUN: begin
                instruction = fetched;
                instr_valid = !is_halt_word;
                if (is_halt_word) begin
                    state_nxt = HALT;
                end
`ifdef FETCH_REDIRECT_EN
                else if (redirect) begin
                    count_nxt = count_inc;
                    if (redirect_oob)
                        state_nxt = HALT;
                    else
                        pc_nxt = redirect_tgt;
                end
`endif
                else if (!stall) begin
                    // Running off the end of memory halts with pc parked on the last word.
                    if (at_last) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = pc + 32'd4;
                        count_nxt = count_inc;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                if (start)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_count <= 16'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for the basic program run plus hand-written
// sequences for mid-run reset, load+start overlap, end-of-memory halt and (optionally) redirect.
module tb_instr_fetch;

    localparam logic [31:0] W_ADD  = 32'h012A_4020;
    localparam logic [31:0] W_SUB  = 32'h018D_5822;
    localparam logic [31:0] W_LW   = 32'h8D09_0004;
    localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W_ADDI = 32'h2008_0064;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        halted;
    logic [15:0] instr_count;
`ifdef FETCH_REDIRECT_EN
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .start       (start),
        .stall       (stall),
`ifdef FETCH_REDIRECT_EN
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`endif
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        load_en;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [15:0] count;
        logic        ready;
    } vec_t;

    vec_t run_tab[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_word(input logic [5:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    // Starts from IDLE and walks the program cycle by cycle against run_tab.
    task automatic run_table(input string tag);
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            stall     = run_tab[i].stall;
            load_en   = run_tab[i].load_en;
            load_addr = 6'd0;
            load_data = 32'h0;
            @(negedge clk);
            check($sformatf("%s[%0d].pc", tag, i), pc, run_tab[i].pc);
            check($sformatf("%s[%0d].instr", tag, i), instruction, run_tab[i].instr);
            check($sformatf("%s[%0d].valid", tag, i), 32'(instr_valid), 32'(run_tab[i].valid));
            check($sformatf("%s[%0d].halted", tag, i), 32'(halted), 32'(run_tab[i].halted));
            check($sformatf("%s[%0d].count", tag, i), 32'(instr_count), 32'(run_tab[i].count));
            check($sformatf("%s[%0d].ready", tag, i), 32'(load_ready), 32'(run_tab[i].ready));
            step();
        end
        stall   = 1'b0;
        load_en = 1'b0;
    endtask

    initial begin
        int cycles;

        //              stall lden  pc      instr   valid halt count ready
        run_tab[0] = '{1'b0, 1'b0, 32'd0,  W_ADD,  1'b1, 1'b0, 16'd0, 1'b0};
        run_tab[1] = '{1'b1, 1'b1, 32'd4,  W_SUB,  1'b1, 1'b0, 16'd1, 1'b0};
        run_tab[2] = '{1'b1, 1'b0, 32'd4,  W_SUB,  1'b1, 1'b0, 16'd1, 1'b0};
        run_tab[3] = '{1'b1, 1'b0, 32'd4,  W_SUB,  1'b1, 1'b0, 16'd1, 1'b0};
        run_tab[4] = '{1'b0, 1'b0, 32'd4,  W_SUB,  1'b1, 1'b0, 16'd1, 1'b0};
        run_tab[5] = '{1'b0, 1'b0, 32'd8,  W_LW,   1'b1, 1'b0, 16'd2, 1'b0};
        run_tab[6] = '{1'b0, 1'b0, 32'd12, W_HALT, 1'b0, 1'b0, 16'd3, 1'b0};
        run_tab[7] = '{1'b0, 1'b0, 32'd12, 32'h0,  1'b0, 1'b1, 16'd3, 1'b0};
        run_tab[8] = '{1'b0, 1'b0, 32'd12, 32'h0,  1'b0, 1'b1, 16'd3, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.pc", pc, 32'h0);
        check("rst.instr", instruction, 32'h0);
        check("rst.valid", 32'(instr_valid), 32'h0);
        check("rst.ready", 32'(load_ready), 32'h1);
        check("rst.halted", 32'(halted), 32'h0);
        check("rst.count", 32'(instr_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        load_word(6'd0, W_ADD);
        load_word(6'd1, W_SUB);
        load_word(6'd2, W_LW);
        load_word(6'd3, W_HALT);

        // Program run with a 3-cycle stall at pc=4 and an ignored write in RUN
        run_table("run1");

        pulse_start();
        check("halt_to_idle.halted", 32'(halted), 32'h0);
        check("halt_to_idle.ready", 32'(load_ready), 32'h1);
        check("halt_to_idle.valid", 32'(instr_valid), 32'h0);
        check("halt_to_idle.instr", instruction, 32'h0);

        // Asynchronous reset mid-run at pc=8
        pulse_start();
        step();
        step();
        check("midrun.pc_before", pc, 32'd8);
        check("midrun.count_before", 32'(instr_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_rst.pc", pc, 32'h0);
        check("midrun_rst.valid", 32'(instr_valid), 32'h0);
        check("midrun_rst.count", 32'(instr_count), 32'h0);
        check("midrun_rst.ready", 32'(load_ready), 32'h1);
        check("midrun_rst.instr", instruction, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Re-run: memory retained and the RUN-time write to word 0 had no effect
        run_table("run2");
        pulse_start();

        // Fill memory with no halt word; word 0 written in the same cycle as start
        for (int a = 1; a < 64; a++)
            load_word(6'(a), W_ADDI);
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = W_ADDI;
        start     = 1'b1;
        step();
        load_en   = 1'b0;
        start     = 1'b0;
        check("load_start.instr", instruction, W_ADDI);
        check("load_start.pc", pc, 32'h0);
        cycles = 0;
        while (!halted && cycles < 200) begin
            if (pc == 32'd252) begin
                check("end.last_valid", 32'(instr_valid), 32'h1);
            end
            step();
            cycles++;
        end
        check("end.cycles", 32'(cycles), 32'd64);
        check("end.halted", 32'(halted), 32'h1);
        check("end.pc", pc, 32'd252);
        check("end.count", 32'(instr_count), 32'd63);

`ifdef FETCH_REDIRECT_EN
        // Redirect beats stall, target is word-aligned; out-of-range target halts
        pulse_start();
        pulse_start();
        step();
        check("redir.pc_before", pc, 32'd4);
        redirect    = 1'b1;
        redirect_pc = 32'h13;
        stall       = 1'b1;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check("redir.pc", pc, 32'h10);
        check("redir.count", 32'(instr_count), 32'd2);
        check("redir.halted_before", 32'(halted), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("redir_oob.halted", 32'(halted), 32'h1);
        check("redir_oob.valid", 32'(instr_valid), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream stage of the single-cycle datapath: owns the PC and a word-addressed instruction memory, and presents one 32-bit instruction per cycle to the control decoder and register file.
- Memory is loaded through a write port while idle; execution starts on a pulse and runs until a halt sentinel or the end of memory.
- PC advances by 4 each cycle unless stalled.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in instruction memory (power of two)
- ADDR_W, 6, word-address width; must equal log2(IMEM_DEPTH)
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset and on start; word aligned
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_en  in  1  write enable for instruction memory
- load_addr  in  ADDR_W  word address of write
- load_data  in  32  instruction word to write
- load_ready  out  1  high when writes are accepted (IDLE only)
- start  in  1  single-cycle pulse, begin execution
- stall  in  1  hold PC and current instruction
- instruction  out  32  instruction to control/decoder
- instr_valid  out  1  instruction is live and must be executed
- pc  out  32  byte address of current instruction
- halted  out  1  fetch has stopped
- instr_count  out  16  instructions issued since start, saturating

Behaviour:
- States: IDLE, RUN, HALT. Encoding is free.
- Reset (asynchronous, any state, mid-run included):
  - state=IDLE, pc=RESET_PC, instr_count=0, halted=0.
  - Memory contents are retained and are never reset.
- Reset output values in IDLE: instruction=0, instr_valid=0, load_ready=1.
- IDLE:
  - load_en=1 writes load_data to imem[load_addr] on the clock edge.
  - start=1 moves to RUN next cycle with pc=RESET_PC and instr_count=0.
  - If load_en and start are asserted in the same cycle, the write completes and is visible in the first RUN cycle.
- RUN:
  - instruction = imem[pc[ADDR_W+1:2]], combinational from the current pc (zero-latency read, single-cycle datapath).
  - instr_valid=1 unless the fetched word equals HALT_WORD.
  - load_ready=0; load_en is ignored and memory is not modified; start is ignored.
  - Each edge with stall=0: pc<=pc+4 and instr_count increments, saturating at 16'hFFFF.
  - stall=1: pc, instruction and instr_count are held; instr_valid stays 1.
  - Fetched word == HALT_WORD (checked regardless of stall):
    - instr_valid=0 in that same cycle;
    - next state HALT;
    - pc frozen at the halt address;
    - the halt word is not counted.
  - Wrap: if the stall=0 increment would move the word index past IMEM_DEPTH-1, next state is HALT and pc holds the last address. There is no wrap to 0.
- HALT:
  - halted=1, instr_valid=0, instruction=0; pc and instr_count are held.
  - start=1 clears halted and moves to IDLE (it does not restart directly); load_ready=1 again from IDLE.
- pc[1:0] is always 2'b00. pc bits above ADDR_W+1 are zero in normal operation.

Optional Feature:
- Macro: FETCH_REDIRECT_EN.
- Defined: adds input ports redirect (1) and redirect_pc (32), used for branch/jump feedback from the datapath.
  - In RUN, redirect=1 sets pc<=redirect_pc & ~32'h3 on the next edge.
  - redirect has priority over stall and over sequential increment.
  - A redirect counts as an issued instruction (instr_count increments).
  - A redirect target whose word index is at or beyond IMEM_DEPTH sends the block to HALT.
  - redirect is ignored in IDLE and HALT, and ignored in the same cycle the HALT_WORD is fetched.
- Undefined: the ports do not exist and PC flow is purely sequential.

Test Plan:
- Load words 0..3 = add, sub, lw, HALT_WORD, then pulse start -> pc 0,4,8,12 on consecutive cycles with instruction matching each word; at pc=12 instr_valid=0; next cycle halted=1, instr_count=3.
- Hold stall high for 3 cycles at pc=4 -> pc stays 4, instruction stays the sub word (32'h018D5822), instr_count unchanged; released -> pc=8 next cycle.
- Fill all 64 words with 32'h20080064 (no halt), start -> after 64 cycles halted=1, pc=252, instr_count=63.
- Assert reset mid-run at pc=8 -> same cycle: state IDLE, pc=0, instr_valid=0, instr_count=0; memory still holds the earlier program; a second start re-runs it identically.
- Assert load_en with addr 0, data 32'h0 while in RUN -> load_ready=0 and imem[0] is unchanged on a later run.
- With FETCH_REDIRECT_EN: at pc=4 assert redirect=1, redirect_pc=32'h13 with stall=1 -> next pc=32'h10; redirect_pc=32'h100 -> HALT.
